// File: rtl/clock_pkg.sv
// clock_pkg: state encoding, BCD digit limits and tick default shared by the clock blocks
package clock_pkg;
  typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_LAP, SW_PAUSE} sw_state_e;
  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
    logic [3:0] ms10;
    logic [3:0] ms1;
  } bcd_time_t;
  localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [3:0] DIGIT_MAX_5 = 4'd5;
  localparam int CS_TICK_DIV = 500000;
  function automatic logic is_counting(sw_state_e s);
    return s == SW_RUN || s == SW_LAP;
  endfunction
endpackage

// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if: mode/button inputs and BCD/status outputs of the stopwatch
interface stopwatch_core_if;
  logic enable;
  logic btn_start_stop;
  logic btn_lap_clear;
  logic [3:0] stp_m10;
  logic [3:0] stp_m1;
  logic [3:0] stp_s10;
  logic [3:0] stp_s1;
  logic [3:0] stp_ms10;
  logic [3:0] stp_ms1;
  logic running;
  logic lap_active;
  logic overflow;
  modport slave (
    input  enable, btn_start_stop, btn_lap_clear,
    output stp_m10, stp_m1, stp_s10, stp_s1, stp_ms10, stp_ms1, running, lap_active, overflow
  );
  modport master (
    output enable, btn_start_stop, btn_lap_clear,
    input  stp_m10, stp_m1, stp_s10, stp_s1, stp_ms10, stp_ms1, running, lap_active, overflow
  );
endinterface

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit 0..MAX with increment, clear and wrap carry
module bcd_digit_counter
  import clock_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX_9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry
);
  logic [3:0] digit_q, digit_d;
  always_comb begin
    carry = inc && digit_q == MAX;
    digit_d = clr ? 4'd0 : carry ? 4'd0 : inc ? digit_q + 4'd1 : digit_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) digit_q <= 4'd0;
    else digit_q <= digit_d;
  assign digit = digit_q;
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: centisecond prescaler, chained BCD count and start/pause/lap/clear FSM
module stopwatch_core
  import clock_pkg::*;
#(
  parameter int TICK_DIV = CS_TICK_DIV
) (
  input logic clk,
  input logic rst,
  stopwatch_core_if.slave sw
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  sw_state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  bcd_time_t snap_q, snap_d, disp_q, disp_d, live;
  logic ovf_q, ovf_d, ovf_out_q, ovf_out_d;
  logic run_q, run_d, lap_q, lap_d;
  logic ss, lc, counting, tick, clr_live;
  logic [5:0] cy;
  logic [3:0] d_ms1, d_ms10, d_s1, d_s10, d_m1, d_m10;
  // start/stop has priority, so lap/clear is dropped when both arrive together
  assign ss = sw.enable && sw.btn_start_stop;
  assign lc = sw.enable && sw.btn_lap_clear && !ss;
  assign counting = is_counting(state_q);
  assign tick = counting && presc_q == PRE_LAST;
  assign clr_live = state_q == SW_PAUSE && lc;
  assign live = '{m10: d_m10, m1: d_m1, s10: d_s10, s1: d_s1, ms10: d_ms10, ms1: d_ms1};
  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_ms1 (
    .clk(clk), .rst(rst), .inc(tick), .clr(clr_live), .digit(d_ms1), .carry(cy[0])
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_ms10 (
    .clk(clk), .rst(rst), .inc(cy[0]), .clr(clr_live), .digit(d_ms10), .carry(cy[1])
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_s1 (
    .clk(clk), .rst(rst), .inc(cy[1]), .clr(clr_live), .digit(d_s1), .carry(cy[2])
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX_5)) u_s10 (
    .clk(clk), .rst(rst), .inc(cy[2]), .clr(clr_live), .digit(d_s10), .carry(cy[3])
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_m1 (
    .clk(clk), .rst(rst), .inc(cy[3]), .clr(clr_live), .digit(d_m1), .carry(cy[4])
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX_5)) u_m10 (
    .clk(clk), .rst(rst), .inc(cy[4]), .clr(clr_live), .digit(d_m10), .carry(cy[5])
  );
  always_comb begin
    state_d = state_q;
    presc_d = counting ? (tick ? '0 : presc_q + PW'(1)) : presc_q;
    snap_d = snap_q;
    ovf_d = ovf_q || cy[5];
    case (state_q)
      SW_IDLE: if (ss) begin
        state_d = SW_RUN;
        presc_d = '0;
      end
      SW_RUN, SW_LAP: if (ss) state_d = SW_PAUSE;
        else if (lc) begin
          state_d = SW_LAP;
          snap_d = live;
        end
      SW_PAUSE: if (ss) state_d = SW_RUN;
        else if (lc) begin
          state_d = SW_IDLE;
          presc_d = '0;
          snap_d = '0;
          ovf_d = 1'b0;
        end
      default: state_d = SW_IDLE;
    endcase
    disp_d = state_q == SW_LAP ? snap_q : live;
    run_d = counting;
    lap_d = state_q == SW_LAP;
    ovf_out_d = ovf_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= SW_IDLE;
      presc_q <= '0;
      snap_q <= '0;
      ovf_q <= 1'b0;
      disp_q <= '0;
      run_q <= 1'b0;
      lap_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      snap_q <= snap_d;
      ovf_q <= ovf_d;
      disp_q <= disp_d;
      run_q <= run_d;
      lap_q <= lap_d;
      ovf_out_q <= ovf_out_d;
    end
  assign sw.stp_m10 = disp_q.m10;
  assign sw.stp_m1 = disp_q.m1;
  assign sw.stp_s10 = disp_q.s10;
  assign sw.stp_s1 = disp_q.s1;
  assign sw.stp_ms10 = disp_q.ms10;
  assign sw.stp_ms1 = disp_q.ms1;
  assign sw.running = run_q;
  assign sw.lap_active = lap_q;
  assign sw.overflow = ovf_out_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: centisecond-integer reference model plus directed literal checks
module tb_stopwatch_core;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  stopwatch_core_if swif();
  stopwatch_core #(.TICK_DIV(TD)) dut (.clk(clk), .rst(rst), .sw(swif));
  int checks = 0;
  int errors = 0;
  bit go = 1'b0;
  int m_st = 0, m_cnt = 0, m_pre = 0, m_snap = 0;
  bit m_ovf = 1'b0;
  int e_disp = 0;
  bit e_run = 1'b0, e_lap = 1'b0, e_ovf = 1'b0;
  bit ld_req = 1'b0;
  int ld_val = 0;
  logic [23:0] act;
  assign act = {swif.stp_m10, swif.stp_m1, swif.stp_s10, swif.stp_s1, swif.stp_ms10, swif.stp_ms1};

  function automatic logic [23:0] to_bcd(int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // states: 0 idle, 1 run, 2 lap, 3 pause; count kept as plain centiseconds
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st <= 0; m_cnt <= 0; m_pre <= 0; m_snap <= 0; m_ovf <= 1'b0;
      e_disp <= 0; e_run <= 1'b0; e_lap <= 1'b0; e_ovf <= 1'b0;
    end else begin : upd
      int st, cnt, pre, snap;
      bit ovf, ss, lc, tk, act_st;
      st = m_st; cnt = ld_req ? ld_val : m_cnt; pre = m_pre; snap = m_snap; ovf = m_ovf;
      e_disp <= st == 2 ? snap : cnt;
      e_run <= st == 1 || st == 2;
      e_lap <= st == 2;
      e_ovf <= ovf;
      ss = swif.enable && swif.btn_start_stop;
      lc = swif.enable && swif.btn_lap_clear && !ss;
      act_st = st == 1 || st == 2;
      tk = act_st && pre == TD - 1;
      if (act_st) pre = tk ? 0 : pre + 1;
      if (act_st && lc) snap = cnt;
      if (tk) begin
        cnt = cnt + 1;
        if (cnt == 360000) begin cnt = 0; ovf = 1'b1; end
      end
      if (st == 0 && ss) begin st = 1; pre = 0; end
      else if (act_st && ss) st = 3;
      else if (st == 1 && lc) st = 2;
      else if (st == 3 && ss) st = 1;
      else if (st == 3 && lc) begin st = 0; cnt = 0; pre = 0; snap = 0; ovf = 1'b0; end
      m_st <= st; m_cnt <= cnt; m_pre <= pre; m_snap <= snap; m_ovf <= ovf;
    end
  end

  always @(negedge clk) if (go) begin
    checks++;
    if (act !== to_bcd(e_disp) || swif.running !== e_run || swif.lap_active !== e_lap ||
        swif.overflow !== e_ovf) begin
      errors++;
      $display("FAIL model t=%0t got disp=%h run=%b lap=%b ovf=%b want disp=%h run=%b lap=%b ovf=%b",
               $time, act, swif.running, swif.lap_active, swif.overflow,
               to_bcd(e_disp), e_run, e_lap, e_ovf);
    end
  end

  task automatic lit(input string nm, input logic [23:0] d, input bit r, input bit l, input bit o);
    checks++;
    if (act !== d || swif.running !== r || swif.lap_active !== l || swif.overflow !== o) begin
      errors++;
      $display("FAIL %s got disp=%h run=%b lap=%b ovf=%b want disp=%h run=%b lap=%b ovf=%b",
               nm, act, swif.running, swif.lap_active, swif.overflow, d, r, l, o);
    end
  endtask

  task automatic pulse(input bit s, input bit l);
    swif.btn_start_stop = s;
    swif.btn_lap_clear = l;
    @(negedge clk);
    swif.btn_start_stop = 1'b0;
    swif.btn_lap_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    swif.enable = 1'b1;
    swif.btn_start_stop = 1'b0;
    swif.btn_lap_clear = 1'b0;
    #1 rst = 1'b0;
    go = 1'b1;
    lit("reset", 24'h000000, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    lit("idle", 24'h000000, 0, 0, 0);
    pulse(0, 1);
    repeat (2) @(negedge clk);
    lit("idle_lc", 24'h000000, 0, 0, 0);
    pulse(1, 0);
    repeat (41) @(negedge clk);
    lit("run10", 24'h000010, 1, 0, 0);
    pulse(1, 0);
    repeat (40) @(negedge clk);
    lit("pause10", 24'h000010, 0, 0, 0);
    pulse(0, 1);
    repeat (2) @(negedge clk);
    lit("clear", 24'h000000, 0, 0, 0);
    pulse(1, 0);
    repeat (20) @(negedge clk);
    pulse(0, 1);
    @(negedge clk);
    lit("lap5", 24'h000005, 1, 1, 0);
    repeat (10) @(negedge clk);
    lit("lap_hold", 24'h000005, 1, 1, 0);
    repeat (16) @(negedge clk);
    pulse(0, 1);
    @(negedge clk);
    lit("lap12", 24'h000012, 1, 1, 0);
    pulse(1, 0);
    @(negedge clk);
    lit("lap_pause", 24'h000012, 0, 0, 0);
    pulse(0, 1);
    repeat (2) @(negedge clk);
    force dut.u_m10.digit_q = 4'd5;
    force dut.u_m1.digit_q = 4'd9;
    force dut.u_s10.digit_q = 4'd5;
    force dut.u_s1.digit_q = 4'd9;
    force dut.u_ms10.digit_q = 4'd9;
    force dut.u_ms1.digit_q = 4'd8;
    ld_val = 359998;
    ld_req = 1'b1;
    @(negedge clk);
    release dut.u_m10.digit_q;
    release dut.u_m1.digit_q;
    release dut.u_s10.digit_q;
    release dut.u_s1.digit_q;
    release dut.u_ms10.digit_q;
    release dut.u_ms1.digit_q;
    ld_req = 1'b0;
    @(negedge clk);
    lit("preload", 24'h595998, 0, 0, 0);
    pulse(1, 0);
    repeat (5) @(negedge clk);
    lit("pre_wrap", 24'h595999, 1, 0, 0);
    repeat (4) @(negedge clk);
    lit("wrap", 24'h000000, 1, 0, 1);
    pulse(1, 0);
    pulse(0, 1);
    @(negedge clk);
    lit("ovf_clr", 24'h000000, 0, 0, 0);
    pulse(1, 0);
    repeat (10) @(negedge clk);
    pulse(1, 1);
    @(negedge clk);
    lit("both", 24'h000002, 0, 0, 0);
    swif.enable = 1'b0;
    pulse(0, 1);
    @(negedge clk);
    lit("en0_lc", 24'h000002, 0, 0, 0);
    pulse(1, 1);
    @(negedge clk);
    lit("en0_ss", 24'h000002, 0, 0, 0);
    swif.enable = 1'b1;
    pulse(1, 0);
    swif.enable = 1'b0;
    pulse(1, 1);
    repeat (5) @(negedge clk);
    lit("en0_run", 24'h000004, 1, 0, 0);
    swif.enable = 1'b1;
    pulse(1, 0);
    pulse(0, 1);
    repeat (2) @(negedge clk);
    pulse(1, 0);
    repeat (492) @(negedge clk);
    pulse(0, 1);
    @(negedge clk);
    lit("lap123", 24'h000123, 1, 1, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 lit("async_rst", 24'h000000, 0, 0, 0);
    @(negedge clk);
    lit("rst_hold", 24'h000000, 0, 0, 0);
    rst = 1'b1;
    pulse(1, 0);
    repeat (5) @(negedge clk);
    lit("restart", 24'h000001, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
